// File: rtl/bsg_cache_pkg.sv
// Shared types for the cache packet front end: opcode encoding, decoded
// control fields, occupancy states and a width-parametrised packet struct.
package bsg_cache_pkg;

  typedef enum logic [4:0] {
    LB      = 5'b00000, LH  = 5'b00001, LW  = 5'b00010, LD  = 5'b00011,
    LBU     = 5'b00100, LHU = 5'b00101, LWU = 5'b00110, LDU = 5'b00111,
    SB      = 5'b01000, SH  = 5'b01001, SW  = 5'b01010, SD  = 5'b01011,
    LM      = 5'b01100, SM  = 5'b01101,
    TAGST   = 5'b10000, TAGFL = 5'b10001, TAGLA = 5'b10010,
    AFL     = 5'b10011, AFLINV = 5'b10100, AINV = 5'b10101,
    ALOCK   = 5'b11000, AUNLOCK = 5'b11001
  } bsg_cache_opcode_e;

  typedef struct packed {
    logic [1:0] size;
    logic       sigext;
    logic       ld_op;
    logic       st_op;
    logic       mask_op;
    logic       tagst;
    logic       tagfl;
    logic       tagla;
    logic       afl;
    logic       aflinv;
    logic       ainv;
    logic       alock;
    logic       aunlock;
    logic       illegal;
    logic       misaligned;
  } bsg_cache_decode_s;

  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } bsg_cache_occ_e;

  localparam int bsg_cache_opcode_width_gp = 5;

endpackage

// Packet layout {opcode, addr, data, mask}, opcode in the MSBs.
`define BSG_CACHE_DECLARE_PKT_S(addr_w, data_w) \
  typedef struct packed { \
    logic [4:0]            opcode; \
    logic [(addr_w)-1:0]   addr; \
    logic [(data_w)-1:0]   data; \
    logic [(data_w)/8-1:0] mask; \
  } bsg_cache_pkt_s

// File: rtl/bsg_cache_pkt_decode_comb.sv
// Pure combinational opcode decoder. Flags ops whose access size exceeds
// the data word as illegal, and flags unaligned byte/half/word/double
// loads and stores as misaligned.
module bsg_cache_pkt_decode_comb
  import bsg_cache_pkg::*;
#(
  parameter int data_width_p = 32
) (
  input  logic [4:0]        opcode,
  input  logic [2:0]        addr_low,
  output bsg_cache_decode_s decode
);

  localparam int         data_bytes_lp = data_width_p / 8;
  localparam logic [1:0] word_size_lp  = 2'($clog2(data_bytes_lp));

  logic [1:0] ss;
  logic [3:0] op_bytes;
  logic [2:0] low_mask;

  assign ss       = opcode[1:0];
  assign op_bytes = 4'd1 << ss;
  assign low_mask = 3'(op_bytes - 4'd1);

  // Map opcode to control fields; anything unmapped leaves only illegal set.
  always_comb begin
    decode = '0;
    case (opcode[4:2])
      3'b000, 3'b001, 3'b010: begin
        if (int'(op_bytes) > data_bytes_lp) begin
          decode.illegal = 1'b1;
        end else begin
          decode.size       = ss;
          decode.ld_op      = ~opcode[3];
          decode.st_op      = opcode[3];
          decode.sigext     = (opcode[4:2] == 3'b000);
          decode.misaligned = |(addr_low & low_mask);
        end
      end
      3'b011: begin
        if (opcode[1] == 1'b0) begin
          decode.size    = word_size_lp;
          decode.mask_op = 1'b1;
          decode.ld_op   = ~opcode[0];
          decode.st_op   = opcode[0];
        end else begin
          decode.illegal = 1'b1;
        end
      end
      default: begin
        case (opcode)
          TAGST:   decode.tagst   = 1'b1;
          TAGFL:   decode.tagfl   = 1'b1;
          TAGLA:   decode.tagla   = 1'b1;
          AFL:     decode.afl     = 1'b1;
          AFLINV:  decode.aflinv  = 1'b1;
          AINV:    decode.ainv    = 1'b1;
          ALOCK:   decode.alock   = 1'b1;
          AUNLOCK: decode.aunlock = 1'b1;
          default: decode.illegal = 1'b1;
        endcase
      end
    endcase
  end

endmodule

// File: rtl/bsg_cache_pkt_decode_buffered.sv
// Registered cache packet decoder with a 2-entry elastic output buffer.
// ready_o comes straight from a flop, so there is no combinational path
// from the output handshake back to the input.
// Optional feature: define BSG_CACHE_PKT_DECODE_ERR_CNT_EN to add a
// saturating 16-bit count of accepted illegal/misaligned packets.
module bsg_cache_pkt_decode_buffered
  import bsg_cache_pkg::*;
#(
  parameter int addr_width_p = 32,
  parameter int data_width_p = 32
) (
  input  logic                                               clk_i,
  input  logic                                               reset_i,
  input  logic                                               v_i,
  output logic                                               ready_o,
  input  logic [5+addr_width_p+data_width_p+data_width_p/8-1:0] cache_pkt_i,
  output logic                                               v_o,
  input  logic                                               yumi_i,
  output bsg_cache_decode_s                                  decode_o,
  output logic [addr_width_p-1:0]                            addr_o,
  output logic [data_width_p-1:0]                            data_o,
  output logic [data_width_p/8-1:0]                          mask_o
`ifdef BSG_CACHE_PKT_DECODE_ERR_CNT_EN
  ,
  output logic [15:0]                                        err_count_o
`endif
);

  `BSG_CACHE_DECLARE_PKT_S(addr_width_p, data_width_p);

  typedef struct packed {
    bsg_cache_decode_s          decode;
    logic [addr_width_p-1:0]    addr;
    logic [data_width_p-1:0]    data;
    logic [data_width_p/8-1:0]  mask;
  } entry_s;

  bsg_cache_pkt_s    pkt;
  bsg_cache_decode_s decode_new;
  entry_s            entry_new;
  entry_s            head_reg, tail_reg;
  bsg_cache_occ_e    state_reg, state_next;
  logic              ready_reg;
  logic              accept, retire;
  logic              load_head, load_tail, shift_tail;

  assign pkt = cache_pkt_i;

  bsg_cache_pkt_decode_comb #(
    .data_width_p(data_width_p)
  ) decoder (
    .opcode  (pkt.opcode),
    .addr_low(pkt.addr[2:0]),
    .decode  (decode_new)
  );

  assign entry_new = '{decode: decode_new, addr: pkt.addr, data: pkt.data, mask: pkt.mask};
  assign accept    = v_i & ready_reg;
  assign retire    = yumi_i & (state_reg != OCC_EMPTY);

  // Occupancy next state and which slot to write; head is always slot 0.
  always_comb begin
    state_next = state_reg;
    load_head  = 1'b0;
    load_tail  = 1'b0;
    shift_tail = 1'b0;
    case (state_reg)
      OCC_EMPTY: begin
        if (accept) begin
          state_next = OCC_ONE;
          load_head  = 1'b1;
        end
      end
      OCC_ONE: begin
        case ({accept, retire})
          2'b11:   load_head = 1'b1;
          2'b10: begin
            state_next = OCC_TWO;
            load_tail  = 1'b1;
          end
          2'b01:   state_next = OCC_EMPTY;
          default: state_next = OCC_ONE;
        endcase
      end
      OCC_TWO: begin
        if (retire) begin
          state_next = OCC_ONE;
          shift_tail = 1'b1;
        end
      end
      default: state_next = OCC_EMPTY;
    endcase
  end

  // Occupancy and registered ready; reset discards any buffered entries.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_reg <= OCC_EMPTY;
      ready_reg <= 1'b1;
    end else begin
      state_reg <= state_next;
      ready_reg <= (state_next != OCC_TWO);
    end
  end

  // Entry storage; contents are only meaningful while the state says so.
  always_ff @(posedge clk_i) begin
    if (load_head) begin
      head_reg <= entry_new;
    end else if (shift_tail) begin
      head_reg <= tail_reg;
    end
    if (load_tail) begin
      tail_reg <= entry_new;
    end
  end

  assign ready_o  = ready_reg;
  assign v_o      = (state_reg != OCC_EMPTY);
  assign decode_o = head_reg.decode;
  assign addr_o   = head_reg.addr;
  assign data_o   = head_reg.data;
  assign mask_o   = head_reg.mask;

`ifdef BSG_CACHE_PKT_DECODE_ERR_CNT_EN
  logic [15:0] err_count_reg;

  // Count bad packets as they are accepted, sticking at all-ones.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      err_count_reg <= '0;
    end else if (accept && (decode_new.illegal || decode_new.misaligned)
                 && (err_count_reg != 16'hFFFF)) begin
      err_count_reg <= err_count_reg + 16'd1;
    end
  end

  assign err_count_o = err_count_reg;
`endif

  // Taking an entry that is not being presented is a consumer bug.
  yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o);

endmodule

// File: tb/tb_bsg_cache_pkt_decode_buffered.sv
// Scoreboard bench for bsg_cache_pkt_decode_buffered (A=32, D=32) plus a
// small D=64 instance for the size-legality boundary.
module tb_bsg_cache_pkt_decode_buffered;
  import bsg_cache_pkg::*;

  localparam int A  = 32;
  localparam int D  = 32;
  localparam int M  = D / 8;
  localparam int PW = 5 + A + D + M;
  localparam int D2 = 64;
  localparam int M2 = D2 / 8;
  localparam int PW2 = 5 + A + D2 + M2;

  logic clk = 1'b0;
  logic reset_i = 1'b1;
  logic v_i = 1'b0;
  logic yumi_en = 1'b0;
  logic [PW-1:0] pkt = '0;
  logic ready_o, v_o, yumi_i;
  bsg_cache_decode_s decode_o;
  logic [A-1:0] addr_o;
  logic [D-1:0] data_o;
  logic [M-1:0] mask_o;
  logic [15:0]  err_count_o;

  logic v64 = 1'b0;
  logic [PW2-1:0] pkt64 = '0;
  logic ready64, v_o64, yumi64;
  bsg_cache_decode_s dec64;
  logic [A-1:0]  addr64;
  logic [D2-1:0] data64;
  logic [M2-1:0] mask64;
  logic [15:0]   err64;

  assign yumi_i = yumi_en & v_o;
  assign yumi64 = v_o64;

  always #5 clk = ~clk;

  bsg_cache_pkt_decode_buffered #(.addr_width_p(A), .data_width_p(D)) dut (
    .clk_i(clk), .reset_i(reset_i), .v_i(v_i), .ready_o(ready_o),
    .cache_pkt_i(pkt), .v_o(v_o), .yumi_i(yumi_i), .decode_o(decode_o),
    .addr_o(addr_o), .data_o(data_o), .mask_o(mask_o)
`ifdef BSG_CACHE_PKT_DECODE_ERR_CNT_EN
    , .err_count_o(err_count_o)
`endif
  );

  bsg_cache_pkt_decode_buffered #(.addr_width_p(A), .data_width_p(D2)) dut64 (
    .clk_i(clk), .reset_i(reset_i), .v_i(v64), .ready_o(ready64),
    .cache_pkt_i(pkt64), .v_o(v_o64), .yumi_i(yumi64), .decode_o(dec64),
    .addr_o(addr64), .data_o(data64), .mask_o(mask64)
`ifdef BSG_CACHE_PKT_DECODE_ERR_CNT_EN
    , .err_count_o(err64)
`endif
  );

`ifndef BSG_CACHE_PKT_DECODE_ERR_CNT_EN
  assign err_count_o = 16'h0;
  assign err64 = 16'h0;
`endif

  typedef struct packed {
    logic [15:0]  dec;
    logic [A-1:0] addr;
    logic [D-1:0] data;
    logic [M-1:0] mask;
  } exp_s;

  exp_s exp_q[$];
  int checks = 0;
  int failures = 0;
  int exp_err = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Monitor: every consumed head entry must match the oldest expectation.
  always @(negedge clk) begin
    if (!reset_i && v_o && yumi_i) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected actual addr=%0h required=no entry", addr_o);
      end else begin
        exp_s e;
        e = exp_q.pop_front();
        check("sb_decode", 64'(decode_o), 64'(e.dec));
        check("sb_addr", 64'(addr_o), 64'(e.addr));
        check("sb_data", 64'(data_o), 64'(e.data));
        check("sb_mask", 64'(mask_o), 64'(e.mask));
        $display("pop addr=%08h dec=%04h", addr_o, decode_o);
      end
    end
  end

  // Hold v_i until the packet is taken; called and returns at posedge+1.
  task automatic send(input logic [4:0] op, input logic [A-1:0] addr, input logic [15:0] dec);
    logic acc;
    int n;
    exp_s e;
    e.dec  = dec;
    e.addr = addr;
    e.data = $urandom;
    e.mask = M'($urandom);
    v_i = 1'b1;
    pkt = {op, addr, e.data, e.mask};
    n = 0;
    acc = 1'b0;
    while (!acc && n < 20) begin
      acc = ready_o;
      @(posedge clk);
      if (acc) begin
        exp_q.push_back(e);
        if ((dec[1] || dec[0]) && exp_err < 65535) exp_err++;
        $display("push op=%05b addr=%08h dec=%04h", op, addr, dec);
      end
      #1;
      n++;
    end
    if (!acc) begin
      checks++;
      failures++;
      $display("FAIL send_timeout actual=not accepted required=accepted op=%05b", op);
    end
  endtask

  task automatic idle(input int cycles);
    v_i = 1'b0;
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send64(input logic [4:0] op, input logic [A-1:0] addr, input logic [15:0] dec, input string name);
    v64 = 1'b1;
    pkt64 = {op, addr, 64'h0123_4567_89AB_CDEF, 8'hA5};
    @(posedge clk);
    #1;
    v64 = 1'b0;
    check({name, "_v"}, 64'(v_o64), 64'd1);
    check(name, 64'(dec64), 64'(dec));
  endtask

  logic [4:0]  t_op  [20] = '{5'b00011, 5'b11111, 5'b00001, 5'b00100, 5'b00110,
                              5'b01010, 5'b01100, 5'b01101, 5'b10000, 5'b10001,
                              5'b10010, 5'b10011, 5'b10100, 5'b10101, 5'b11000,
                              5'b11001, 5'b01110, 5'b10110, 5'b00000, 5'b01011};
  logic [31:0] t_addr[20] = '{32'h1, 32'h0, 32'h2, 32'h3, 32'h2,
                              32'h8, 32'h4, 32'h4, 32'h5, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h0, 32'h0,
                              32'h0, 32'h0, 32'h0, 32'h7, 32'h0};
  logic [15:0] t_dec [20] = '{16'h0002, 16'h0002, 16'h7000, 16'h1000, 16'h9001,
                              16'h8800, 16'h9400, 16'h8C00, 16'h0200, 16'h0100,
                              16'h0080, 16'h0040, 16'h0020, 16'h0010, 16'h0008,
                              16'h0004, 16'h0002, 16'h0002, 16'h3000, 16'h0002};

  initial begin
    int n;
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("reset_v_o", 64'(v_o), 64'd0);
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    check("post_reset_ready", 64'(ready_o), 64'd1);
    check("post_reset_v_o", 64'(v_o), 64'd0);
`ifdef BSG_CACHE_PKT_DECODE_ERR_CNT_EN
    check("post_reset_err", 64'(err_count_o), 64'd0);
`endif

    // Aligned signed word load, visible the cycle after acceptance
    yumi_en = 1'b1;
    send(5'b00010, 32'h100, 16'hB000);
    v_i = 1'b0;
    check("t1_v_o_latency", 64'(v_o), 64'd1);
    idle(1);

    // Misaligned halfword store bumps the error count
    send(5'b01001, 32'h101, 16'h4801);
    v_i = 1'b0;
`ifdef BSG_CACHE_PKT_DECODE_ERR_CNT_EN
    check("t2_err_count", 64'(err_count_o), 64'(exp_err));
`endif
    idle(1);

    // Back-to-back opcode sweep with the consumer always taking
    for (int i = 0; i < 20; i++) send(t_op[i], t_addr[i], t_dec[i]);
    idle(3);
`ifdef BSG_CACHE_PKT_DECODE_ERR_CNT_EN
    check("sweep_err_count", 64'(err_count_o), 64'(exp_err));
`endif

    // Fill both entries with the consumer stalled
    yumi_en = 1'b0;
    send(5'b00010, 32'h200, 16'hB000);
    send(5'b00110, 32'h204, 16'h9000);
    v_i = 1'b1;
    pkt = {5'b01010, 32'h208, 32'h0, 4'h0};
    check("t4_full_ready", 64'(ready_o), 64'd0);
    check("t4_full_v_o", 64'(v_o), 64'd1);
    idle(0);
    @(posedge clk);
    #1;
    check("t4_still_full", 64'(ready_o), 64'd0);
    yumi_en = 1'b1;
    send(5'b01010, 32'h208, 16'h8800);
    send(5'b01000, 32'h20B, 16'h0800);
    send(5'b00101, 32'h20E, 16'h5000);
    send(5'b00001, 32'h211, 16'h7001);
    v_i = 1'b0;
    n = 0;
    while (v_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("t4_drain_v_o", 64'(v_o), 64'd0);
    check("t4_sb_empty", 64'(exp_q.size()), 64'd0);

    // Asynchronous reset while both entries are held
    yumi_en = 1'b0;
    send(5'b00010, 32'h300, 16'hB000);
    send(5'b00010, 32'h304, 16'hB000);
    v_i = 1'b0;
    #2;
    reset_i = 1'b1;
    #1;
    check("t5_async_v_o", 64'(v_o), 64'd0);
    exp_q.delete();
    exp_err = 0;
    @(posedge clk);
    #1;
    reset_i = 1'b0;
    @(posedge clk);
    #1;
    check("t5_post_ready", 64'(ready_o), 64'd1);
    check("t5_post_v_o", 64'(v_o), 64'd0);
`ifdef BSG_CACHE_PKT_DECODE_ERR_CNT_EN
    check("t5_post_err", 64'(err_count_o), 64'd0);
`endif
    yumi_en = 1'b1;
    send(5'b01100, 32'h400, 16'h9400);
    idle(3);
    check("t5_sb_empty", 64'(exp_q.size()), 64'd0);

`ifdef BSG_CACHE_PKT_DECODE_ERR_CNT_EN
    // Saturation of the error counter
    force dut.err_count_reg = 16'hFFFE;
    @(posedge clk);
    #1;
    release dut.err_count_reg;
    exp_err = 16'hFFFE;
    check("t6_forced", 64'(err_count_o), 64'h FFFE);
    send(5'b11111, 32'h0, 16'h0002);
    send(5'b01110, 32'h0, 16'h0002);
    send(5'b00011, 32'h0, 16'h0002);
    idle(3);
    check("t6_saturated", 64'(err_count_o), 64'hFFFF);
`endif

    // Same opcodes against a 64-bit data path
    send64(5'b00011, 32'h10, 16'hF000, "d64_ld_aligned");
    send64(5'b00011, 32'h4,  16'hF001, "d64_ld_misaligned");
    send64(5'b01101, 32'h8,  16'hCC00, "d64_sm_size");
    check("d64_ready", 64'(ready64), 64'd1);
    idle(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

endmodule
